// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Brief    : Instruction-memory request bus plus the fetch-to-decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int N = 64
);
    import fetch_pkg::*;

    logic                imem_req;
    logic [N-1:0]        imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                instr_valid_F;
    logic [INSTR_W-1:0]  instr_F;
    logic [N-1:0]        pc_F;
    logic                instr_ready_D;

    modport master (
        output imem_req, imem_addr, instr_valid_F, instr_F, pc_F,
        input  imem_ack, imem_rdata, instr_ready_D
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid_F, instr_F, pc_F,
        output imem_ack, imem_rdata, instr_ready_D
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Prefetch buffer; synchronous clear overrides a same-cycle push.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    i_push,
    input  wire logic [WIDTH-1:0]        i_data,
    input  wire logic                    i_pop,
    input  wire logic                    i_clear,
    output logic      [WIDTH-1:0]        o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic      [$clog2(DEPTH):0]  o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (c_ptr_w+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch with prefetch buffer and branch redirect.
//            Define FETCH_PERF_EN to add redirect/discard counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int           N        = 64,
    parameter int           DEPTH    = 2,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         PCSrc_W,
    input  wire logic [N-1:0] PCBranch_W,
    fetch_if.master           bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       redirect_cnt,
    output logic [31:0]       discard_cnt
`endif
);

    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_fifo_w = N + INSTR_W;

    fetch_state_t         r_state;
    fetch_state_t         w_state_next;
    logic [N-1:0]         r_pc;
    logic [N-1:0]         w_pc_next;
    logic [N-1:0]         r_hold_addr;
    logic [N-1:0]         w_hold_addr_next;
    logic [N-1:0]         w_target;
    logic                 w_ack;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_cnt_w-1:0]   w_fifo_count;
    logic [c_fifo_w-1:0]  w_fifo_rdata;

    assign w_target = PCBranch_W & ~N'(3);
    assign w_ack    = bus.imem_req && bus.imem_ack;
    assign w_pop    = bus.instr_valid_F && bus.instr_ready_D;

    assign bus.imem_req      = reset && (r_state != HOLD);
    assign bus.imem_addr     = (r_state == DISCARD) ? r_hold_addr : r_pc;
    assign bus.instr_valid_F = reset && !w_fifo_empty && !PCSrc_W;
    assign {bus.pc_F, bus.instr_F} = w_fifo_rdata;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_hold_addr_next = r_hold_addr;
        w_push           = 1'b0;
        case (r_state)
            FETCH: begin
                if (PCSrc_W) begin
                    w_pc_next = w_target;
                    // Without an ack the old request is still in flight and
                    // its address must stay on the bus until it completes.
                    if (!w_ack) begin
                        w_state_next     = DISCARD;
                        w_hold_addr_next = r_pc;
                    end
                end else if (w_ack && !w_fifo_full) begin
                    w_push    = 1'b1;
                    w_pc_next = r_pc + N'(PC_INC);
                    if (!w_pop && (w_fifo_count == c_cnt_w'(DEPTH - 1))) begin
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (PCSrc_W) begin
                    w_pc_next    = w_target;
                    w_state_next = FETCH;
                end else if (w_pop) begin
                    w_state_next = FETCH;
                end
            end
            DISCARD: begin
                if (PCSrc_W) begin
                    w_pc_next = w_target;
                end
                if (w_ack) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_hold_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_hold_addr <= w_hold_addr_next;
        end
    end

    fetch_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_pc, bus.imem_rdata}),
        .i_pop   (w_pop),
        .i_clear (PCSrc_W),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic w_drop;

    // A returned word is dropped when it arrives during DISCARD or together
    // with a redirect in FETCH.
    assign w_drop = w_ack && ((r_state == DISCARD) || ((r_state == FETCH) && PCSrc_W));

    always_ff @(posedge clk) begin
        if (!reset) begin
            redirect_cnt <= '0;
            discard_cnt  <= '0;
        end else begin
            if (PCSrc_W && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 32'd1;
            if (w_drop && (discard_cnt != '1))   discard_cnt  <= discard_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit with a variable-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int N     = 64;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          PCSrc_W = 1'b0;
    logic [N-1:0]  PCBranch_W = '0;
    int            mem_lat = 0;
    logic [7:0]    wait_cnt;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [N+31:0] exp_q[$];
    logic [N-1:0]  addr_q[$];
    logic [N+31:0] mon_e;
    logic [N-1:0]  mon_a;
`ifdef FETCH_PERF_EN
    logic [31:0]   redirect_cnt;
    logic [31:0]   discard_cnt;
`endif

    fetch_if #(.N(N)) bus();

    fetch_unit #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PCSrc_W      (PCSrc_W),
        .PCBranch_W   (PCBranch_W),
        .bus          (bus)
`ifdef FETCH_PERF_EN
        ,
        .redirect_cnt (redirect_cnt),
        .discard_cnt  (discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [N-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    // Memory model: acknowledges after mem_lat waiting cycles (0 = same cycle).
    assign bus.imem_ack   = bus.imem_req && (int'(wait_cnt) >= mem_lat);
    assign bus.imem_rdata = word_of(bus.imem_addr);

    always @(posedge clk) begin
        if (!reset || !bus.imem_req || bus.imem_ack) wait_cnt <= 8'd0;
        else                                         wait_cnt <= wait_cnt + 8'd1;
    end

    task automatic chk(input string name, input logic [N+31:0] act, input logic [N+31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.instr_valid_F && bus.instr_ready_D) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pop: got pc %h, expected no instruction", bus.pc_F);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pop {pc_F,instr_F}", {bus.pc_F, bus.instr_F}, mon_e);
                end
            end
            if (bus.imem_req && bus.imem_ack) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: got addr %h, expected no request", bus.imem_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    chk("acked imem_addr", bus.imem_addr, mon_a);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [N-1:0] pc);
        exp_q.push_back({pc, word_of(pc)});
    endtask

    // Drains the previous test, holds reset for two edges, then releases it.
    task automatic start_test(input int lat, input logic rdy);
        chk("exp_q drained", exp_q.size(), 0);
        chk("addr_q drained", addr_q.size(), 0);
        exp_q.delete();
        addr_q.delete();
        reset = 1'b0;
        PCSrc_W = 1'b0;
        PCBranch_W = '0;
        mem_lat = lat;
        bus.instr_ready_D = rdy;
        cyc();
        mid();
        chk("reset imem_req", bus.imem_req, 0);
        chk("reset instr_valid_F", bus.instr_valid_F, 0);
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.instr_ready_D = 1'b1;

        // Free-running fetch, single-cycle memory, decode always ready
        start_test(0, 1'b1);
        for (int i = 0; i < 4; i++) addr_q.push_back(N'(4 * i));
        for (int i = 0; i < 3; i++) push_exp(N'(4 * i));
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("t1 imem_req", bus.imem_req, 1);
            chk("t1 imem_addr", bus.imem_addr, N'(4 * i));
            chk("t1 instr_valid_F", bus.instr_valid_F, (i != 0));
            cyc();
        end

        // Buffer fills with decode stalled, one pop restarts fetching
        start_test(0, 1'b0);
        addr_q.push_back(N'(0)); addr_q.push_back(N'(4)); addr_q.push_back(N'(8));
        push_exp(N'(0));
        mid(); chk("t2 c0 imem_req", bus.imem_req, 1); cyc();
        mid(); chk("t2 c1 imem_addr", bus.imem_addr, N'(4)); cyc();
        mid(); chk("t2 hold imem_req", bus.imem_req, 0);
               chk("t2 hold instr_valid_F", bus.instr_valid_F, 1); cyc();
        bus.instr_ready_D = 1'b1;
        mid(); chk("t2 pop cycle imem_req", bus.imem_req, 0); cyc();
        bus.instr_ready_D = 1'b0;
        mid(); chk("t2 after pop imem_req", bus.imem_req, 1);
               chk("t2 after pop imem_addr", bus.imem_addr, N'(8)); cyc();
        mid(); chk("t2 refilled imem_req", bus.imem_req, 0);
               chk("t2 refilled pc_F", bus.pc_F, N'(4)); cyc();

        // Redirect to 0x103 while the request to 0x8 waits three cycles
        start_test(0, 1'b1);
        addr_q.push_back(N'(0)); addr_q.push_back(N'(4)); addr_q.push_back(N'(8));
        push_exp(N'(0));
        mid(); cyc();
        mid(); cyc();
        mem_lat = 3;
        bus.instr_ready_D = 1'b0;
        mid(); chk("t3 c2 imem_addr", bus.imem_addr, N'(8));
               chk("t3 c2 imem_ack", bus.imem_ack, 0); cyc();
        PCSrc_W = 1'b1;
        PCBranch_W = N'(64'h103);
        mid(); chk("t3 redirect instr_valid_F", bus.instr_valid_F, 0);
               chk("t3 redirect imem_addr", bus.imem_addr, N'(8)); cyc();
        PCSrc_W = 1'b0;
        mid(); chk("t3 discard imem_addr", bus.imem_addr, N'(8));
               chk("t3 discard imem_req", bus.imem_req, 1);
               chk("t3 discard instr_valid_F", bus.instr_valid_F, 0); cyc();
        mid(); chk("t3 late ack", bus.imem_ack, 1);
               chk("t3 late ack imem_addr", bus.imem_addr, N'(8)); cyc();
        mid(); chk("t3 target imem_addr", bus.imem_addr, N'(64'h100));
               chk("t3 target imem_req", bus.imem_req, 1);
               chk("t3 target instr_valid_F", bus.instr_valid_F, 0);
`ifdef FETCH_PERF_EN
               chk("t3 redirect_cnt", redirect_cnt, 1);
               chk("t3 discard_cnt", discard_cnt, 1);
`endif
        cyc();

        // Redirect coincides with an ack and a ready decode stage
        start_test(0, 1'b1);
        addr_q.push_back(N'(0)); addr_q.push_back(N'(4));
        addr_q.push_back(N'(64'h200)); addr_q.push_back(N'(64'h204));
        push_exp(N'(64'h200));
        mid(); cyc();
        PCSrc_W = 1'b1;
        PCBranch_W = N'(64'h200);
        mid(); chk("t4 redirect instr_valid_F", bus.instr_valid_F, 0);
               chk("t4 redirect imem_ack", bus.imem_ack, 1); cyc();
        PCSrc_W = 1'b0;
        mid(); chk("t4 target imem_addr", bus.imem_addr, N'(64'h200));
               chk("t4 no stale instr_valid_F", bus.instr_valid_F, 0); cyc();
        mid(); chk("t4 target instr_valid_F", bus.instr_valid_F, 1);
               chk("t4 target pc_F", bus.pc_F, N'(64'h200));
`ifdef FETCH_PERF_EN
               chk("t4 redirect_cnt", redirect_cnt, 1);
               chk("t4 discard_cnt", discard_cnt, 1);
`endif
        cyc();

        // Top-of-address-space wrap; low target bits are masked off
        start_test(0, 1'b1);
        addr_q.push_back(N'(0)); addr_q.push_back({{(N-2){1'b1}}, 2'b00});
        addr_q.push_back(N'(0)); addr_q.push_back(N'(4));
        push_exp({{(N-2){1'b1}}, 2'b00});
        push_exp(N'(0));
        PCSrc_W = 1'b1;
        PCBranch_W = '1;
        mid(); cyc();
        PCSrc_W = 1'b0;
        mid(); chk("t5 top imem_addr", bus.imem_addr, {{(N-2){1'b1}}, 2'b00}); cyc();
        mid(); chk("t5 wrapped imem_addr", bus.imem_addr, N'(0));
               chk("t5 top pc_F", bus.pc_F, {{(N-2){1'b1}}, 2'b00}); cyc();
        mid(); cyc();

        // Reset asserted while a wrong-path request is outstanding
        start_test(5, 1'b1);
        PCSrc_W = 1'b1;
        PCBranch_W = N'(64'h40);
        mid(); chk("t6 c0 imem_ack", bus.imem_ack, 0); cyc();
        PCSrc_W = 1'b0;
        mid(); chk("t6 discard imem_addr", bus.imem_addr, N'(0));
               chk("t6 discard imem_req", bus.imem_req, 1); cyc();
        reset = 1'b0;
        mid(); chk("t6 in reset imem_req", bus.imem_req, 0); cyc();
        reset = 1'b1;
        mid(); chk("t6 released imem_addr", bus.imem_addr, N'(0));
               chk("t6 released imem_req", bus.imem_req, 1);
`ifdef FETCH_PERF_EN
               chk("t6 redirect_cnt", redirect_cnt, 0);
               chk("t6 discard_cnt", discard_cnt, 0);
`endif
        cyc();

        reset = 1'b0;
        cyc();
        chk("final exp_q drained", exp_q.size(), 0);
        chk("final addr_q drained", addr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
